// File: rtl/lcd_id_detect_if.sv
// Panel-ID pin/result bundle between the LCD pin side and the identification block.
// Latency: none (wires only).
// Backpressure: none; rd_req is a single-cycle pulse and the results are level signals.
//
// Signals:
//   strap_in    raw, asynchronous strap pins {R7,G7,B7} -> [2]=R7, [1]=G7, [0]=B7
//   rd_req      single-cycle re-detect request
//   bus_release 1 = LCD RGB drivers must be tri-stated
//   lcd_id      decoded panel ID
//   h_disp      active horizontal pixels
//   v_disp      active vertical lines
//   id_valid    lcd_id/h_disp/v_disp are valid
//   id_err      detection failed (timeout or unknown code)
interface lcd_id_detect_if #(
   parameter int ID_BITS = 3
) ();
   logic [ID_BITS-1:0] strap_in;
   logic               rd_req;
   logic               bus_release;
   logic [15:0]        lcd_id;
   logic [10:0]        h_disp;
   logic [10:0]        v_disp;
   logic               id_valid;
   logic               id_err;

   // pin/controller side: supplies straps and re-detect requests, consumes results
   modport master (
      output strap_in,
      output rd_req,
      input  bus_release,
      input  lcd_id,
      input  h_disp,
      input  v_disp,
      input  id_valid,
      input  id_err
   );

   // detector side
   modport slave (
      input  strap_in,
      input  rd_req,
      output bus_release,
      output lcd_id,
      output h_disp,
      output v_disp,
      output id_valid,
      output id_err
   );
endinterface

// File: rtl/lcd_id_detect.sv
// Power-up LCD panel identification: release bus, settle, debounce straps, decode to ID + resolution.
// Latency: id_valid rises SETTLE_CYC + STABLE_CNT + 1 cycles after reset release (straps stable).
// Backpressure: none; rd_req honoured only in DONE/ERR, ignored (not queued) elsewhere.
//
// Ports:
//   sys_clk  system clock (only clock)
//   sys_rst  asynchronous active-low reset
//   lcd      lcd_id_detect_if.slave: strap_in/rd_req in; bus_release, lcd_id, h_disp,
//            v_disp, id_valid, id_err out (all outputs registered)
module lcd_id_detect #(
   parameter int ID_BITS     = 3,
   parameter int SETTLE_CYC  = 1000,
   parameter int STABLE_CNT  = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   lcd_id_detect_if.slave  lcd
);

   localparam logic [2:0] ST_SETTLE = 3'd0;
   localparam logic [2:0] ST_SAMPLE = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_ERR    = 3'd4;

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int KW = $clog2(STABLE_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
   // stable count before the sample that completes the run
   localparam logic [KW-1:0] STABLE_LAST = KW'(STABLE_CNT - 1);
   // tmo value whose increment lands on TIMEOUT_CYC-1; leaving then gives TIMEOUT_CYC-... cycles in SAMPLE
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 2);

   // ---------------------------------------------------------------- state
   logic [2:0]         r_state;
   logic               r_entry;       // first cycle in SAMPLE: load prev, restart counts
   logic [SW-1:0]      r_settle_cnt;
   logic [KW-1:0]      r_stable;
   logic [TW-1:0]      r_tmo;
   logic [ID_BITS-1:0] r_sync1;
   logic [ID_BITS-1:0] r_sync2;
   logic [ID_BITS-1:0] r_prev;
   logic [ID_BITS-1:0] r_code;

   logic               r_bus_release;
   logic [15:0]        r_lcd_id;
   logic [10:0]        r_h_disp;
   logic [10:0]        r_v_disp;
   logic               r_id_valid;
   logic               r_id_err;

   // ---------------------------------------------------------------- strap synchroniser
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= lcd.strap_in;
         r_sync2 <= r_sync1;
      end
   end

   // ---------------------------------------------------------------- decode table
   logic        w_upper_zero;
   logic        w_known;
   logic [15:0] w_id;
   logic [10:0] w_h;
   logic [10:0] w_v;

   // bits above [2] are reserved and must read zero; with ID_BITS==3 the shift yields 0
   assign w_upper_zero = ((r_code >> 3) == '0);

   always_comb begin
      w_known = 1'b0;
      w_id    = 16'h0000;
      w_h     = 11'd0;
      w_v     = 11'd0;
      if (w_upper_zero) begin
         case (r_code[2:0])
            3'b000: begin w_known = 1'b1; w_id = 16'h4342; w_h = 11'd480;  w_v = 11'd272; end
            3'b001: begin w_known = 1'b1; w_id = 16'h7084; w_h = 11'd800;  w_v = 11'd480; end
            3'b010: begin w_known = 1'b1; w_id = 16'h7016; w_h = 11'd1024; w_v = 11'd600; end
            3'b100: begin w_known = 1'b1; w_id = 16'h4384; w_h = 11'd800;  w_v = 11'd480; end
            3'b101: begin w_known = 1'b1; w_id = 16'h1018; w_h = 11'd1280; w_v = 11'd800; end
            default: begin
               w_known = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- sample qualifiers
   logic w_match;
   logic w_stable_hit;
   logic w_timeout;

   assign w_match      = (r_sync2 == r_prev);
   assign w_stable_hit = !r_entry && w_match && (r_stable == STABLE_LAST);
   // stability wins if both land on the same cycle
   assign w_timeout    = !r_entry && !w_stable_hit && (r_tmo == TMO_LAST);

   // ---------------------------------------------------------------- control FSM
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         r_state       <= ST_SETTLE;
         r_entry       <= 1'b0;
         r_settle_cnt  <= '0;
         r_stable      <= '0;
         r_tmo         <= '0;
         r_prev        <= '0;
         r_code        <= '0;
         r_bus_release <= 1'b1;
         r_lcd_id      <= 16'h0000;
         r_h_disp      <= 11'd0;
         r_v_disp      <= 11'd0;
         r_id_valid    <= 1'b0;
         r_id_err      <= 1'b0;
      end else begin
         case (r_state)
            ST_SETTLE: begin
               r_bus_release <= 1'b1;
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_settle_cnt <= '0;
                  r_entry      <= 1'b1;
                  r_state      <= ST_SAMPLE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
               end
            end

            ST_SAMPLE: begin
               if (r_entry) begin
                  r_entry  <= 1'b0;
                  r_prev   <= r_sync2;
                  r_stable <= KW'(1);
                  r_tmo    <= '0;
               end else if (w_stable_hit) begin
                  r_code   <= r_prev;
                  r_stable <= '0;
                  r_tmo    <= '0;
                  r_state  <= ST_DECODE;
               end else if (w_timeout) begin
                  r_stable      <= '0;
                  r_tmo         <= '0;
                  r_state       <= ST_ERR;
                  r_bus_release <= 1'b0;
                  r_lcd_id      <= 16'h0000;
                  r_h_disp      <= 11'd0;
                  r_v_disp      <= 11'd0;
                  r_id_valid    <= 1'b0;
                  r_id_err      <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
                  if (w_match) begin
                     r_stable <= r_stable + 1'b1;
                  end else begin
                     // any change restarts the run from this new value
                     r_stable <= KW'(1);
                     r_prev   <= r_sync2;
                  end
               end
            end

            ST_DECODE: begin
               r_bus_release <= 1'b0;
               if (w_known) begin
                  r_state    <= ST_DONE;
                  r_lcd_id   <= w_id;
                  r_h_disp   <= w_h;
                  r_v_disp   <= w_v;
                  r_id_valid <= 1'b1;
                  r_id_err   <= 1'b0;
               end else begin
                  r_state    <= ST_ERR;
                  r_lcd_id   <= 16'h0000;
                  r_h_disp   <= 11'd0;
                  r_v_disp   <= 11'd0;
                  r_id_valid <= 1'b0;
                  r_id_err   <= 1'b1;
               end
            end

            ST_DONE, ST_ERR: begin
               // result fields stay held until the next decode overwrites them
               if (lcd.rd_req) begin
                  r_state       <= ST_SETTLE;
                  r_settle_cnt  <= '0;
                  r_bus_release <= 1'b1;
                  r_id_valid    <= 1'b0;
                  r_id_err      <= 1'b0;
               end
            end

            default: begin
               r_state       <= ST_SETTLE;
               r_settle_cnt  <= '0;
               r_bus_release <= 1'b1;
               r_id_valid    <= 1'b0;
               r_id_err      <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign lcd.bus_release = r_bus_release;
   assign lcd.lcd_id      = r_lcd_id;
   assign lcd.h_disp      = r_h_disp;
   assign lcd.v_disp      = r_v_disp;
   assign lcd.id_valid    = r_id_valid;
   assign lcd.id_err      = r_id_err;

endmodule
